rv32i_mem_arbiter: RTL

Shares one single-port synchronous word SRAM between the core's instruction-fetch port and its load/store port. It replaces the split imem/dmem in `top` when a unified memory is configured. Each cycle it grants at most one requester and drives the SRAM. It routes the 1-cycle-latency read data back to the owner and flags out-of-range addresses. Load/store has priority, with a starvation guard so fetch always makes progress.

---
 rtl/rv32i_mem_pkg.sv | 27 ++
 rtl/rv32i_arb_pick.sv | 58 +++++
 rtl/rv32i_mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
//   owner_t : which requester owns the response slot next cycle
//   resp_t  : registered response descriptor (owner, read/write tag, error)
//   out_of_range() : true when a byte address lies beyond the SRAM
package rv32i_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   is_read;
        logic   err;
    } resp_t;

    // Any set bit above the word-address field means the access misses the SRAM.
    function automatic logic out_of_range(input logic [WORD_W-1:0] addr, input int addr_w);
        return (addr >> (addr_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/rv32i_arb_pick.sv
// Combinational requester pick with a fetch starvation guard.
//   clk, reset_n    : clock, asynchronous active-low reset
//   if_req, ls_req  : fetch / load-store requests
//   if_gnt, ls_gnt  : one-hot (or zero) grants, same cycle as the requests
// Load/store normally wins; once fetch has been turned away MAX_WAIT cycles
// in a row it takes the next contested cycle.
module rv32i_arb_pick #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic       starved;

    assign starved = (wait_cnt_reg == MAX_WAIT_C);

    always_comb begin
        if_gnt        = 1'b0;
        ls_gnt        = 1'b0;
        wait_cnt_next = wait_cnt_reg;

        if (if_req && ls_req) begin
            if (starved) begin
                if_gnt = 1'b1;
            end else begin
                ls_gnt = 1'b1;
            end
        end else begin
            if_gnt = if_req;
            ls_gnt = ls_req;
        end

        // Count only uninterrupted denials; a grant or a withdrawn request restarts it.
        if (!if_req || if_gnt) begin
            wait_cnt_next = '0;
        end else if (!starved) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port synchronous word SRAM between instruction fetch and
// load/store.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt          : fetch request and same-cycle grant
//   if_rvalid/if_rdata/if_err         : fetch response, cycle after grant
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata -> ls_gnt : load/store request, grant
//   ls_rvalid/ls_rdata/ls_err         : load response / store error pulse
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata : SRAM port
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic  if_oor;
    logic  ls_oor;
    logic  sel_oor;
    logic  granted;
    resp_t resp_reg;
    resp_t resp_next;
    logic  unused_addr_lsbs;

    // Byte offset within the word is irrelevant to a word SRAM.
    assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

    rv32i_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk     (clk),
        .reset_n (reset_n),
        .if_req  (if_req),
        .ls_req  (ls_req),
        .if_gnt  (if_gnt),
        .ls_gnt  (ls_gnt)
    );

    assign if_oor  = out_of_range(if_addr, ADDR_W);
    assign ls_oor  = out_of_range(ls_addr, ADDR_W);
    assign granted = if_gnt | ls_gnt;
    assign sel_oor = ls_gnt ? ls_oor : if_oor;

    // SRAM drive: an out-of-range grant still gets a response, but never
    // touches the array, so out-of-range stores are silently dropped.
    always_comb begin
        mem_en    = granted & ~sel_oor;
        mem_we    = ls_gnt & ls_we;
        mem_be    = (ls_gnt && ls_we) ? ls_be : 4'hF;
        mem_addr  = ls_gnt ? ls_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        mem_wdata = ls_wdata;
    end

    always_comb begin
        resp_next.owner   = OWN_NONE;
        resp_next.is_read = 1'b0;
        resp_next.err     = 1'b0;
        if (ls_gnt) begin
            resp_next.owner   = OWN_LS;
            resp_next.is_read = ~ls_we;
            resp_next.err     = ls_oor;
        end else if (if_gnt) begin
            resp_next.owner   = OWN_IF;
            resp_next.is_read = 1'b1;
            resp_next.err     = if_oor;
        end
    end

    // Reset discards any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_reg <= '{owner: OWN_NONE, is_read: 1'b0, err: 1'b0};
        end else begin
            resp_reg <= resp_next;
        end
    end

    // Response routing; read data is forced to zero on errors and when idle.
    always_comb begin
        if_rvalid = (resp_reg.owner == OWN_IF);
        if_err    = if_rvalid & resp_reg.err;
        if_rdata  = (if_rvalid && !resp_reg.err) ? mem_rdata : '0;
        ls_rvalid = (resp_reg.owner == OWN_LS) & resp_reg.is_read;
        ls_err    = (resp_reg.owner == OWN_LS) & resp_reg.err;
        ls_rdata  = (ls_rvalid && !resp_reg.err) ? mem_rdata : '0;
    end

endmodule
